spider_return: RTL and testbench
================================

Name: spider_return

Overview:
- Return path of the spider datapath: carries traffic from the four right-side legs back toward the single left-side body.
- Each of four input lanes feeds a small per-lane FIFO. A round-robin arbiter merges the lanes onto one registered output stream, tagged with the source lane.
- All interfaces use valid/ready handshakes; backpressure propagates lane-by-lane.

Parameters:
- W, 8, data width per lane.
- DEPTH, 2, per-lane FIFO depth in entries; power of 2, minimum 2.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  4  per-lane valid; bit i = leg_right(i+1).
- in_data  input  4*W  lane i occupies bits [i*W +: W].
- in_ready  output  4  per-lane ready.
- out_valid  output  1  merged output valid.
- out_data  output  W  merged output data.
- out_lane  output  2  source lane of out_data (0..3).
- out_ready  input  1  downstream ready.
- lane_busy  output  4  bit i high when FIFO i is non-empty.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - Lane FIFO pointers and counts cleared.
  - out_valid=0, out_data=0, out_lane=0, round-robin pointer rr=0, lane_busy=0.
  - in_ready=0 while rst is high.
  - Reset mid-transfer discards all buffered words; no partial state survives.
- Lane input:
  - in_ready[i] = !rst && count[i] != DEPTH. This is a function of registered count only; no same-cycle pop-through.
  - A push occurs on an edge where in_valid[i] && in_ready[i].
  - A full FIFO refuses input even if it is popped in the same cycle.
  - Senders may drop in_valid without penalty; once valid is asserted, data is sampled only on acceptance.
- Output register (one entry):
  - The stage is "free" when !out_valid || out_ready.
  - When free and any lane is non-empty, grant the first non-empty lane searching rr, rr+1, rr+2, rr+3 (mod 4).
  - On grant, at the clock edge:
    - out_data <= head of granted FIFO.
    - out_lane <= grant.
    - out_valid <= 1.
    - Pop the granted FIFO.
    - rr <= grant+1 mod 4.
  - When free and no lane is non-empty: out_valid <= 0; out_data and out_lane hold their last values.
  - When not free (out_valid && !out_ready): out_valid, out_data and out_lane hold stable; no pop; rr unchanged.
- Latency and throughput:
  - A word accepted into an empty lane on edge E is granted on edge E+1 at the earliest, so out_valid is high in the cycle after E+1.
  - Sustained throughput is 1 word/cycle with out_ready held high.
- Simultaneous events:
  - A push and pop on the same lane in the same cycle leaves count unchanged; both pointers advance (mod DEPTH, wrap-around).
  - Push into a full FIFO is impossible by construction.
  - Pop of an empty FIFO is impossible (a lane is granted only if non-empty).
- Ordering:
  - Per-lane order is preserved.
  - Cross-lane order follows round-robin only; no starvation. Any non-empty lane is granted within 4 output transfers.
- lane_busy[i] = count[i] != 0, registered-derived.

Test Plan:
- Reset check: assert rst mid-cycle with 2 words in lane 1 → immediately out_valid=0, in_ready=0, lane_busy=0. After release, in_ready=4'hF and no stale word appears.
- Single word: in_valid=4'b0100, lane 2 data=8'hA5 accepted on edge E → out_valid=1, out_data=A5, out_lane=2 after edge E+1.
- Round-robin: all lanes hold one word (lane i data = 8'h10+i), rr=0, out_ready=1 → output order lanes 0,1,2,3 on consecutive cycles. Then push lane 0 and lane 3 together → lane 0 is granted first (rr=0 after lane 3).
- Backpressure: out_ready=0 with lane 0 receiving 3 words (DEPTH=2) → out_valid stable with word0. Lane 0 FIFO holds word1, word2; in_ready[0]=0. Releasing out_ready → word0, word1, word2 in order; in_ready[0] returns 1 after the first pop.
- Wrap and concurrency: lane 3 streamed with 20 words 0..19, out_ready=1 → all 20 delivered in order with out_lane=3. Count exercises push+pop in the same cycle and pointer wrap; no gaps after the first.
- Fairness: lanes 0 and 1 continuously valid, out_ready=1 for 16 cycles → out_lane alternates 0,1,0,1…, giving 8 grants each.

Source files
------------

// File: rtl/spider_return.sv
// spider_return: return path of the spider datapath.
//
// Four right-side leg lanes each feed a small FIFO. A round-robin arbiter
// drains the FIFOs into a single registered output stage tagged with the
// source lane, heading back to the left-side body.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   per-lane valid, bit i = leg_right(i+1)
//   in_data    per-lane data, lane i at [i*W +: W]
//   in_ready   per-lane ready (depends on registered FIFO count only)
//   out_valid  merged output valid
//   out_data   merged output data
//   out_lane   source lane of out_data
//   out_ready  downstream ready
//   lane_busy  bit i high when FIFO i holds at least one word
module spider_return #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     in_valid,
    input  logic [4*W-1:0] in_data,
    output logic [3:0]     in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [1:0]     out_lane,
    input  logic           out_ready,
    output logic [3:0]     lane_busy
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    // Per-lane FIFO state
    logic [W-1:0]    mem_q   [4][DEPTH];
    logic [PtrW-1:0] wptr_q  [4];
    logic [PtrW-1:0] rptr_q  [4];
    logic [CntW-1:0] count_q [4];

    // Arbiter and output stage state
    logic [1:0]   rr_q;
    logic         out_valid_q;
    logic [W-1:0] out_data_q;
    logic [1:0]   out_lane_q;

    // Combinational control
    logic [3:0]   full;
    logic [3:0]   push;
    logic [3:0]   pop;
    logic         stage_free;
    logic         grant_found;
    logic [1:0]   grant;
    logic [1:0]   cand;
    logic [W-1:0] head_data;

    // ------------------------------------------------------------------
    // Lane status and input handshake
    // ------------------------------------------------------------------
    always_comb begin
        full      = '0;
        lane_busy = '0;
        for (int i = 0; i < 4; i++) begin
            full[i]      = (count_q[i] == CntW'(DEPTH));
            lane_busy[i] = (count_q[i] != '0);
        end
    end

    // Ready depends on the registered count only: a full lane stays closed
    // even in a cycle where it is being popped, which keeps in_ready free of
    // any path from out_ready.
    assign in_ready = rst ? 4'b0000 : ~full;
    assign push     = in_valid & in_ready;

    // ------------------------------------------------------------------
    // Round-robin arbitration
    // ------------------------------------------------------------------
    assign stage_free = !out_valid_q || out_ready;

    always_comb begin
        grant       = rr_q;
        grant_found = 1'b0;
        cand        = '0;
        for (int k = 0; k < 4; k++) begin
            // Search order rr, rr+1, rr+2, rr+3 with natural 2-bit wrap.
            cand = rr_q + 2'(k);
            if (!grant_found && lane_busy[cand]) begin
                grant       = cand;
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        pop = '0;
        if (stage_free && grant_found) begin
            pop[grant] = 1'b1;
        end
    end

    assign head_data = mem_q[grant][rptr_q[grant]];

    // ------------------------------------------------------------------
    // FIFO storage: data RAM carries no reset; validity lives in count_q.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
                mem_q[i][wptr_q[i]] <= in_data[i*W +: W];
            end
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                wptr_q[i]  <= '0;
                rptr_q[i]  <= '0;
                count_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) begin
                    wptr_q[i] <= wptr_q[i] + PtrW'(1);
                end
                if (pop[i]) begin
                    rptr_q[i] <= rptr_q[i] + PtrW'(1);
                end
                unique case ({push[i], pop[i]})
                    2'b10:   count_q[i] <= count_q[i] + CntW'(1);
                    2'b01:   count_q[i] <= count_q[i] - CntW'(1);
                    default: count_q[i] <= count_q[i];
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_lane_q  <= '0;
            rr_q        <= '0;
        end else if (stage_free) begin
            if (grant_found) begin
                out_valid_q <= 1'b1;
                out_data_q  <= head_data;
                out_lane_q  <= grant;
                rr_q        <= grant + 2'd1;
            end else begin
                // Data and lane keep their last values when the stage empties.
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_lane  = out_lane_q;

endmodule

// File: tb/tb_spider_return.sv
// Self-checking bench for spider_return: directed scenarios plus a random
// phase, all checked cycle by cycle against a queue-based reference model.
module tb_spider_return;

    localparam int W     = 8;
    localparam int DEPTH = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [3:0]     in_valid = '0;
    logic [4*W-1:0] in_data = '0;
    logic [3:0]     in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_lane;
    logic           out_ready = 1'b0;
    logic [3:0]     lane_busy;

    spider_return #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_ready (out_ready),
        .lane_busy (lane_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one queue per lane plus the output register contents.
    logic [W-1:0] mq [4][$];
    logic         m_ovalid = 1'b0;
    logic [W-1:0] m_odata  = '0;
    logic [1:0]   m_olane  = '0;
    int           m_rr     = 0;
    logic [3:0]   last_acc = '0;

    // Transfers actually seen on the DUT output, {lane, data}.
    logic [W+1:0] obs [$];

    task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs_v === exp_v)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs_v, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mq[i].delete();
        m_ovalid = 1'b0;
        m_odata  = '0;
        m_olane  = '0;
        m_rr     = 0;
    endtask

    task automatic compare_all();
        logic [3:0] exp_ready;
        logic [3:0] exp_busy;
        for (int i = 0; i < 4; i++) begin
            exp_ready[i] = !rst && (mq[i].size() < DEPTH);
            exp_busy[i]  = (mq[i].size() != 0);
        end
        chk("in_ready",  32'(in_ready),  32'(exp_ready));
        chk("lane_busy", 32'(lane_busy), 32'(exp_busy));
        chk("out_valid", 32'(out_valid), 32'(m_ovalid));
        chk("out_data",  32'(out_data),  32'(m_odata));
        chk("out_lane",  32'(out_lane),  32'(m_olane));
    endtask

    // One clock: evaluate the model against the inputs presented now,
    // take the edge, advance the model, then compare #1 after the edge.
    task automatic step();
        logic [3:0]   acc;
        logic [W-1:0] din [4];
        bit           free;
        bit           found;
        int           g;
        int           l;
        acc   = '0;
        free  = 1'b0;
        found = 1'b0;
        g     = 0;
        for (int i = 0; i < 4; i++) din[i] = in_data[i*W +: W];
        if (!rst) begin
            if (out_valid && out_ready) obs.push_back({out_lane, out_data});
            for (int i = 0; i < 4; i++) acc[i] = in_valid[i] && (mq[i].size() < DEPTH);
            free = !m_ovalid || out_ready;
            for (int k = 0; k < 4; k++) begin
                l = (m_rr + k) % 4;
                if (!found && mq[l].size() != 0) begin
                    found = 1'b1;
                    g     = l;
                end
            end
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (free && found) begin
                m_odata  = mq[g].pop_front();
                m_olane  = 2'(g);
                m_ovalid = 1'b1;
                m_rr     = (g + 1) % 4;
            end else if (free) begin
                m_ovalid = 1'b0;
            end
            for (int i = 0; i < 4; i++) if (acc[i]) mq[i].push_back(din[i]);
        end
        last_acc = acc;
        #1;
        compare_all();
    endtask

    // Present one word on a lane and hold it until accepted; valid is left high.
    task automatic send_lane(input int lane, input logic [W-1:0] data);
        bit ok;
        ok = 1'b0;
        in_valid[lane]        = 1'b1;
        in_data[lane*W +: W]  = data;
        for (int t = 0; t < 20; t++) begin
            step();
            if (last_acc[lane]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $error("FAIL send_timeout: lane %0d word %0h never accepted", lane, data);
        end
    endtask

    task automatic idle(input int n);
        for (int t = 0; t < n; t++) step();
    endtask

    initial begin
        int cnt0;
        bit ok;
        logic [W+1:0] e;

        // ---------------- Reset state ----------------
        #1 rst = 1'b1;
        #2;
        compare_all();
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'hF);
        compare_all();

        // ---------------- Single word latency ----------------
        out_ready = 1'b1;
        obs.delete();
        in_data[2*W +: W] = 8'hA5;
        in_valid = 4'b0100;
        step();                                  // edge E: accepted
        in_valid = '0;
        chk("single_not_yet", 32'(out_valid), 32'h0);
        step();                                  // edge E+1: granted
        chk("single_valid", 32'(out_valid), 32'h1);
        chk("single_data",  32'(out_data),  32'hA5);
        chk("single_lane",  32'(out_lane),  32'h2);
        idle(2);

        // ---------------- Reset mid-transfer ----------------
        out_ready = 1'b0;
        send_lane(1, 8'h31);
        send_lane(1, 8'h32);
        send_lane(1, 8'h33);
        in_valid = '0;
        chk("pre_rst_busy", 32'(lane_busy[1]), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'h0);
        chk("mid_rst_busy",      32'(lane_busy), 32'h0);
        model_reset();
        step();
        #2 rst = 1'b0;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'hF);
        out_ready = 1'b1;
        obs.delete();
        idle(4);
        chk("no_stale_words", 32'(obs.size()), 32'h0);

        // ---------------- Round robin ----------------
        obs.delete();
        for (int i = 0; i < 4; i++) in_data[i*W +: W] = 8'(8'h10 + i);
        in_valid = 4'hF;
        step();
        in_valid = '0;
        idle(5);
        chk("rr_count", 32'(obs.size()), 32'h4);
        for (int i = 0; i < 4 && i < obs.size(); i++) begin
            e = obs[i];
            chk("rr_lane", 32'(e[W+1:W]), 32'(i));
            chk("rr_data", 32'(e[W-1:0]), 32'(8'h10 + i));
        end
        obs.delete();
        in_data[0*W +: W] = 8'h40;
        in_data[3*W +: W] = 8'h43;
        in_valid = 4'b1001;
        step();
        in_valid = '0;
        idle(4);
        chk("rr2_count", 32'(obs.size()), 32'h2);
        if (obs.size() >= 2) begin
            chk("rr2_first",  32'(obs[0]), 32'({2'd0, 8'h40}));
            chk("rr2_second", 32'(obs[1]), 32'({2'd3, 8'h43}));
        end

        // ---------------- Backpressure ----------------
        obs.delete();
        out_ready = 1'b0;
        send_lane(0, 8'hB0);
        send_lane(0, 8'hB1);
        send_lane(0, 8'hB2);
        in_valid = '0;
        idle(3);
        chk("bp_in_ready0", 32'(in_ready[0]), 32'h0);
        chk("bp_out_valid", 32'(out_valid),   32'h1);
        chk("bp_out_data",  32'(out_data),    32'hB0);
        out_ready = 1'b1;
        step();
        chk("bp_ready_back", 32'(in_ready[0]), 32'h1);
        idle(4);
        chk("bp_count", 32'(obs.size()), 32'h3);
        for (int i = 0; i < 3 && i < obs.size(); i++) begin
            chk("bp_order", 32'(obs[i]), 32'({2'd0, 8'(8'hB0 + i)}));
        end

        // ---------------- Wrap and concurrency on lane 3 ----------------
        obs.delete();
        for (int k = 0; k < 20; k++) send_lane(3, 8'(k));
        in_valid = '0;
        idle(4);
        chk("stream_count", 32'(obs.size()), 32'd20);
        for (int k = 0; k < 20 && k < obs.size(); k++) begin
            chk("stream_word", 32'(obs[k]), 32'({2'd3, 8'(k)}));
        end

        // ---------------- Fairness ----------------
        obs.delete();
        in_valid = 4'b0011;
        for (int t = 0; t < 20; t++) begin
            in_data = 32'($urandom);
            step();
        end
        in_valid = '0;
        idle(4);
        ok = (obs.size() >= 17);
        if (!ok) begin
            n_cmp++;
            n_err++;
            $error("FAIL fair_timeout: observed %0d transfers expected at least 17", obs.size());
        end else begin
            cnt0 = 0;
            for (int k = 1; k <= 16; k++) begin
                e = obs[k];
                if (e[W+1:W] == 2'd0) cnt0++;
                chk("fair_alternate", 32'(e[W+1:W] != obs[k-1][W+1:W]), 32'h1);
            end
            chk("fair_count0", 32'(cnt0), 32'd8);
        end

        // ---------------- Random traffic ----------------
        for (int t = 0; t < 400; t++) begin
            in_valid  = 4'($urandom);
            in_data   = 32'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = '0;
        out_ready = 1'b1;
        idle(12);
        chk("drain_busy",  32'(lane_busy), 32'h0);
        chk("drain_valid", 32'(out_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
